// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states,
// decoder width/sign (bmc) encodings and access legality checks.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } lsu_state_e;

   localparam logic [2:0] BMC_B  = 3'b000;
   localparam logic [2:0] BMC_H  = 3'b001;
   localparam logic [2:0] BMC_W  = 3'b010;
   localparam logic [2:0] BMC_BU = 3'b100;
   localparam logic [2:0] BMC_HU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] bmc, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (bmc)
         BMC_H, BMC_HU: mis = addr_lo[0];
         BMC_W:         mis = (addr_lo != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Unsigned widths only make sense for loads; a store with them is illegal.
   function automatic logic is_legal_bmc(input logic [2:0] bmc, input logic is_load);
      logic ok;
      ok = 1'b0;
      case (bmc)
         BMC_B, BMC_H, BMC_W: ok = 1'b1;
         BMC_BU, BMC_HU:      ok = is_load;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores (strobes + replicated data) and
// byte/half extraction with sign or zero extension for loads.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  bmc,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  st_strb,
   output logic [31:0] st_lanes,
   output logic [31:0] ld_ext
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte  = rd_word[{addr_lo, 3'b000} +: 8];
      ld_half  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
      st_strb  = 4'b0000;
      st_lanes = 32'h0000_0000;
      ld_ext   = 32'h0000_0000;
      case (bmc)
         BMC_B, BMC_BU: begin
            st_strb  = 4'b0001 << addr_lo;
            st_lanes = {4{st_data[7:0]}};
            ld_ext   = bmc[2] ? {24'h00_0000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         end
         BMC_H, BMC_HU: begin
            st_strb  = 4'b0011 << addr_lo;
            st_lanes = {2{st_data[15:0]}};
            ld_ext   = bmc[2] ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
         end
         BMC_W: begin
            st_strb  = 4'b1111;
            st_lanes = st_data;
            ld_ext   = rd_word;
         end
         default: begin
            st_strb  = 4'b0000;
            st_lanes = 32'h0000_0000;
            ld_ext   = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns decoder mr/mw/bmc + ALU address into a
// req/ack/rvalid bus transaction and stalls the PC while it is outstanding.
module lsu_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mr,
   input  logic        mw,
   input  logic [2:0]  bmc,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic        bus_rvalid
);
   import lsu_pkg::*;

   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_wstrb_q, bus_wstrb_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        ld_valid_q, ld_valid_d;
   logic        err_q, err_d;
   logic [2:0]  bmc_q, bmc_d;
   logic [1:0]  addr_lo_q, addr_lo_d;

   logic        access, is_load, legal;
   logic [2:0]  al_bmc;
   logic [1:0]  al_addr_lo;
   logic [3:0]  st_strb;
   logic [31:0] st_lanes, ld_ext;

   assign access  = mr | mw;
   assign is_load = mr;
   assign legal   = is_legal_bmc(bmc, is_load) & ~is_misaligned(bmc, addr[1:0]);

   // The aligner sees live decoder fields when launching, latched ones afterwards.
   assign al_bmc     = (state_q == IDLE) ? bmc : bmc_q;
   assign al_addr_lo = (state_q == IDLE) ? addr[1:0] : addr_lo_q;

   lsu_align u_align (
      .bmc      (al_bmc),
      .addr_lo  (al_addr_lo),
      .st_data  (wdata),
      .rd_word  (bus_rdata),
      .st_strb  (st_strb),
      .st_lanes (st_lanes),
      .ld_ext   (ld_ext)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_wdata_d = bus_wdata_q;
      ld_data_d   = ld_data_q;
      ld_valid_d  = 1'b0;
      err_d       = 1'b0;
      bmc_d       = bmc_q;
      addr_lo_d   = addr_lo_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (legal) begin
                  bus_req_d   = 1'b1;
                  bus_we_d    = ~is_load;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_wstrb_d = is_load ? 4'b0000 : st_strb;
                  bus_wdata_d = is_load ? 32'h0000_0000 : st_lanes;
                  bmc_d       = bmc;
                  addr_lo_d   = addr[1:0];
                  cnt_d       = '0;
                  state_d     = REQ;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (bus_ack && (bus_we_q || bus_rvalid)) begin
               bus_req_d = 1'b0;
               state_d   = DONE;
               if (!bus_we_q) begin
                  ld_data_d  = ld_ext;
                  ld_valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               bus_req_d = 1'b0;
               err_d     = 1'b1;
               state_d   = DONE;
               if (!bus_we_q) ld_data_d = 32'h0000_0000;
            end else if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = WAIT_R;
            end
         end
         WAIT_R: begin
            cnt_d = cnt_q + CW'(1);
            if (bus_rvalid) begin
               ld_data_d  = ld_ext;
               ld_valid_d = 1'b1;
               state_d    = DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d     = 1'b1;
               ld_data_d = 32'h0000_0000;
               state_d   = DONE;
            end
         end
         DONE: begin
            // The retiring instruction's mr/mw are still up here; never relaunch.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0000_0000;
         bus_wstrb_q <= 4'b0000;
         bus_wdata_q <= 32'h0000_0000;
         ld_data_q   <= 32'h0000_0000;
         ld_valid_q  <= 1'b0;
         err_q       <= 1'b0;
         bmc_q       <= 3'b000;
         addr_lo_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_wdata_q <= bus_wdata_d;
         ld_data_q   <= ld_data_d;
         ld_valid_q  <= ld_valid_d;
         err_q       <= err_d;
         bmc_q       <= bmc_d;
         addr_lo_q   <= addr_lo_d;
      end
   end

   assign stall     = (state_q != DONE) & access & ~rst;
   assign ld_data   = ld_data_q;
   assign ld_valid  = ld_valid_q;
   assign err       = err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads with extension, illegal
// accesses, bus timeout and reset during an outstanding read.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        mr;
   logic        mw;
   logic [2:0]  bmc;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;

   int checks   = 0;
   int failures = 0;

   lsu_ctrl #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .mr         (mr),
      .mw         (mw),
      .bmc        (bmc),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .ld_data    (ld_data),
      .ld_valid   (ld_valid),
      .err        (err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wstrb  (bus_wstrb),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Step into the next cycle; inputs are driven and outputs sampled mid-cycle.
   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic store_fast(input string tag, input logic [2:0] b, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wd);
      mr = 1'b0; mw = 1'b1; bmc = b; addr = a; wdata = d;
      #1 chk({tag, "_idle_stall"}, 32'(stall), 32'h1);
      nxt();
      bus_ack = 1'b1;
      #1;
      chk({tag, "_req"},   32'(bus_req), 32'h1);
      chk({tag, "_we"},    32'(bus_we), 32'h1);
      chk({tag, "_addr"},  bus_addr, {a[31:2], 2'b00});
      chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
      chk({tag, "_wdata"}, bus_wdata, exp_wd);
      chk({tag, "_req_stall"}, 32'(stall), 32'h1);
      nxt();
      bus_ack = 1'b0;
      #1;
      chk({tag, "_done_stall"}, 32'(stall), 32'h0);
      chk({tag, "_done_ldv"},   32'(ld_valid), 32'h0);
      chk({tag, "_done_err"},   32'(err), 32'h0);
      chk({tag, "_done_req"},   32'(bus_req), 32'h0);
      nxt();
      mr = 1'b0; mw = 1'b0;
   endtask

   task automatic load_fast(input string tag, input logic mw_in, input logic [2:0] b,
                            input logic [31:0] a, input logic [31:0] rd,
                            input logic [31:0] exp_ld);
      mr = 1'b1; mw = mw_in; bmc = b; addr = a; wdata = 32'hFFFF_FFFF;
      #1 chk({tag, "_idle_stall"}, 32'(stall), 32'h1);
      nxt();
      bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = rd;
      #1;
      chk({tag, "_req"},  32'(bus_req), 32'h1);
      chk({tag, "_we"},   32'(bus_we), 32'h0);
      chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, "_req_stall"}, 32'(stall), 32'h1);
      nxt();
      bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0BAD_0BAD;
      #1;
      chk({tag, "_ldv"},   32'(ld_valid), 32'h1);
      chk({tag, "_data"},  ld_data, exp_ld);
      chk({tag, "_err"},   32'(err), 32'h0);
      chk({tag, "_done_stall"}, 32'(stall), 32'h0);
      chk({tag, "_done_req"},   32'(bus_req), 32'h0);
      nxt();
      mr = 1'b0; mw = 1'b0;
      #1;
      chk({tag, "_ldv_pulse"}, 32'(ld_valid), 32'h0);
      chk({tag, "_hold"},      ld_data, exp_ld);
   endtask

   task automatic illegal(input string tag, input logic mr_in, input logic mw_in,
                          input logic [2:0] b, input logic [31:0] a);
      mr = mr_in; mw = mw_in; bmc = b; addr = a;
      #1 chk({tag, "_idle_stall"}, 32'(stall), 32'h1);
      nxt();
      #1;
      chk({tag, "_err"},   32'(err), 32'h1);
      chk({tag, "_req"},   32'(bus_req), 32'h0);
      chk({tag, "_stall"}, 32'(stall), 32'h0);
      chk({tag, "_ldv"},   32'(ld_valid), 32'h0);
      nxt();
      mr = 1'b0; mw = 1'b0;
      #1;
      chk({tag, "_err_pulse"}, 32'(err), 32'h0);
      chk({tag, "_req_after"}, 32'(bus_req), 32'h0);
   endtask

   initial begin
      rst = 1'b1; mr = 1'b0; mw = 1'b0; bmc = 3'b000; addr = 32'h0; wdata = 32'h0;
      bus_ack = 1'b0; bus_rdata = 32'h0; bus_rvalid = 1'b0;
      nxt();
      nxt();
      mr = 1'b1;
      #1 chk("rst_stall_masked", 32'(stall), 32'h0);
      mr = 1'b0;
      nxt();
      rst = 1'b0;
      #1;
      chk("rst_bus_req",   32'(bus_req), 32'h0);
      chk("rst_bus_we",    32'(bus_we), 32'h0);
      chk("rst_bus_addr",  bus_addr, 32'h0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_ld_data",   ld_data, 32'h0);
      chk("rst_ld_valid",  32'(ld_valid), 32'h0);
      chk("rst_err",       32'(err), 32'h0);
      chk("rst_stall",     32'(stall), 32'h0);
      nxt();

      store_fast("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);

      // Halfword load with rvalid three cycles after ack: five stall cycles.
      mr = 1'b1; mw = 1'b0; bmc = 3'b001; addr = 32'h0000_2002;
      #1 chk("lh_stall_c0", 32'(stall), 32'h1);
      nxt();
      bus_ack = 1'b1;
      #1;
      chk("lh_req",       32'(bus_req), 32'h1);
      chk("lh_addr",      bus_addr, 32'h0000_2000);
      chk("lh_stall_c1",  32'(stall), 32'h1);
      nxt();
      bus_ack = 1'b0;
      #1;
      chk("lh_req_drop",  32'(bus_req), 32'h0);
      chk("lh_stall_c2",  32'(stall), 32'h1);
      nxt();
      #1 chk("lh_stall_c3", 32'(stall), 32'h1);
      nxt();
      bus_rvalid = 1'b1; bus_rdata = 32'h8001_7FFF;
      #1 chk("lh_stall_c4", 32'(stall), 32'h1);
      chk("lh_ldv_early", 32'(ld_valid), 32'h0);
      nxt();
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      #1;
      chk("lh_ldv",        32'(ld_valid), 32'h1);
      chk("lh_data",       ld_data, 32'hFFFF_8001);
      chk("lh_err",        32'(err), 32'h0);
      chk("lh_done_stall", 32'(stall), 32'h0);
      nxt();
      mr = 1'b0;

      load_fast("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
      load_fast("lb",  1'b0, 3'b000, 32'h0000_0011, 32'h0000_8000, 32'hFFFF_FF80);
      load_fast("lbu_mrmw", 1'b1, 3'b100, 32'h0000_0023, 32'hC300_0000, 32'h0000_00C3);
      store_fast("sh", 3'b001, 32'h0000_000A, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
      store_fast("sw", 3'b010, 32'h0000_0050, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

      illegal("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h0000_3001);
      illegal("sbu_store",     1'b0, 1'b1, 3'b100, 32'h0000_0010);
      illegal("bmc_011",       1'b1, 1'b0, 3'b011, 32'h0000_0000);

      // Reset while waiting for rvalid; a late rvalid must be ignored.
      mr = 1'b1; mw = 1'b0; bmc = 3'b010; addr = 32'h0000_0048;
      nxt();
      bus_ack = 1'b1;
      #1 chk("rstw_req", 32'(bus_req), 32'h1);
      nxt();
      bus_ack = 1'b0; rst = 1'b1; mr = 1'b0;
      #1 chk("rstw_stall", 32'(stall), 32'h0);
      nxt();
      rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rstw_bus_req",   32'(bus_req), 32'h0);
      chk("rstw_bus_addr",  bus_addr, 32'h0);
      chk("rstw_bus_wdata", bus_wdata, 32'h0);
      chk("rstw_bus_wstrb", 32'(bus_wstrb), 32'h0);
      chk("rstw_ld_data",   ld_data, 32'h0);
      chk("rstw_ld_valid",  32'(ld_valid), 32'h0);
      chk("rstw_err",       32'(err), 32'h0);
      nxt();
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      #1;
      chk("rstw_late_ldv",  32'(ld_valid), 32'h0);
      chk("rstw_late_data", ld_data, 32'h0);
      chk("rstw_late_req",  32'(bus_req), 32'h0);

      load_fast("lw_after_rst", 1'b0, 3'b010, 32'h0000_0040, 32'h1234_5678, 32'h1234_5678);

      // Load acked but never returned: abandoned after four REQ/WAIT_R cycles.
      mr = 1'b1; mw = 1'b0; bmc = 3'b010; addr = 32'h0000_0044;
      nxt();
      bus_ack = 1'b1;
      #1 chk("to_ld_req", 32'(bus_req), 32'h1);
      nxt();
      bus_ack = 1'b0;
      #1 chk("to_ld_req_drop", 32'(bus_req), 32'h0);
      nxt();
      nxt();
      #1;
      chk("to_ld_last_err",   32'(err), 32'h0);
      chk("to_ld_last_stall", 32'(stall), 32'h1);
      nxt();
      #1;
      chk("to_ld_err",   32'(err), 32'h1);
      chk("to_ld_data",  ld_data, 32'h0);
      chk("to_ld_ldv",   32'(ld_valid), 32'h0);
      chk("to_ld_req_done", 32'(bus_req), 32'h0);
      chk("to_ld_stall", 32'(stall), 32'h0);
      nxt();
      mr = 1'b0;
      #1 chk("to_ld_err_pulse", 32'(err), 32'h0);

      // Store never acked: bus_req held four cycles, then dropped with err.
      mr = 1'b0; mw = 1'b1; bmc = 3'b010; addr = 32'h0000_0060; wdata = 32'h0000_0001;
      nxt();
      #1 chk("to_st_req_c0", 32'(bus_req), 32'h1);
      nxt();
      #1 chk("to_st_req_c1", 32'(bus_req), 32'h1);
      nxt();
      nxt();
      #1;
      chk("to_st_req_c3", 32'(bus_req), 32'h1);
      chk("to_st_err_c3", 32'(err), 32'h0);
      nxt();
      #1;
      chk("to_st_err",   32'(err), 32'h1);
      chk("to_st_req",   32'(bus_req), 32'h0);
      chk("to_st_stall", 32'(stall), 32'h0);
      nxt();
      mw = 1'b0;
      #1 chk("to_st_idle_req", 32'(bus_req), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the instruction decoder and the data-memory bus. It turns the decoder's MR/MW/BMC controls plus the ALU address into a req/ack/rvalid bus transaction and stalls the PC while the access is outstanding. It also performs byte-lane steering, load sign/zero extension and misalignment/timeout detection. It sits beside the register-file writeback mux and feeds its MD=1 input.

## Interface
Parameters:
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT_R before the access is abandoned (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- mr  in  1  decoder memory-read
- mw  in  1  decoder memory-write
- bmc  in  3  decoder funct3 (width/sign)
- addr  in  32  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC and IR this cycle
- ld_data  out  32  extended load result, registered
- ld_valid  out  1  one-cycle pulse, ld_data updated
- err  out  1  one-cycle pulse: misaligned, illegal bmc or timeout
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-steered store data
- bus_ack  in  1  request accepted
- bus_rdata  in  32  read word
- bus_rvalid  in  1  bus_rdata valid

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, no access (mr|mw=0): stay.
- IDLE, access is legal: latch bus outputs, go to REQ.
- IDLE, access is illegal (misaligned or illegal bmc): go to DONE with err pending; no bus traffic.
- REQ: bus_req=1, held with stable outputs until bus_ack.
  - bus_ack on a write: go to DONE.
  - bus_ack on a read with bus_rvalid in the same cycle: capture, go to DONE.
  - bus_ack on a read without bus_rvalid: go to WAIT_R.
- WAIT_R: on bus_rvalid, capture and go to DONE.
- DONE: always goes to IDLE. It never re-triggers on the still-asserted mr/mw of the retiring instruction.
- stall = (state≠DONE) & (mr|mw) & ~rst.
- bmc encodings: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned. 100/101 are legal for loads only. Every other code is illegal → err.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- Stores:
  - wstrb: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - wdata is replicated: byte to all four lanes, half to both halves.
- Loads:
  - Select the byte/half from bus_rdata using addr[1:0].
  - Sign-extend for 000/001; zero-extend for 100/101.
- mr=mw=1 is treated as a load; the write is suppressed.
- Timeout: a counter clears on IDLE→REQ and increments in REQ/WAIT_R. When it reaches TIMEOUT without completion, drop bus_req and go to DONE with err. If it was a load, ld_data=0.
- Reset:
  - State returns to IDLE; all registered outputs go to 0; the counter clears.
  - A bus_ack/bus_rvalid arriving in IDLE is ignored.

## Timing
- Reset values: bus_req 0, bus_we 0, bus_addr 0, bus_wstrb 0, bus_wdata 0, ld_data 0, ld_valid 0, err 0, stall 0.
- Best-case access (ack, plus rvalid for loads, in the first REQ cycle) takes 3 cycles: IDLE(stall=1), REQ(stall=1), DONE(stall=0).
  - ld_valid and err are high during DONE.
  - The PC advances at the end of DONE.
- Each additional bus wait cycle adds one stall cycle.
- Illegal access takes 2 cycles: IDLE(stall=1) then DONE(err=1).
- Bus outputs are registered and change only on the IDLE→REQ edge. bus_req deasserts on the edge after bus_ack.
- ld_data holds its value until the next capture.

## Structure
- Shared package `lsu_pkg`:
  - state enum
  - BMC_B/H/W/BU/HU constants
  - helper function is_misaligned(bmc, addr[1:0])
- One combinational sub-module, `lsu_align`: store lane steering/strobes and load extract/extend. The FSM, timeout counter and bus registers stay in lsu_ctrl.
- Counter width: $clog2(TIMEOUT+1).

## Test plan
- SB: addr=0x1003, wdata=0xA5, ack in REQ → bus_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, stall high 2 cycles, no ld_valid.
- LH: addr=0x2002, rdata=0x8001_7FFF, rvalid 3 cycles after ack → ld_data=0xFFFF8001, stall high 5 cycles. Same access as LHU → ld_data=0x00008001.
- LW: addr=0x3001 → err pulse in DONE, bus_req never asserts, stall high 1 cycle.
- Store with bmc=100 → err, no bus traffic.
- TIMEOUT=4, ack but never rvalid → err at DONE after 4 REQ/WAIT_R cycles, ld_data=0, bus_req low.
- rst asserted in WAIT_R, then late rvalid → state IDLE, ld_valid stays 0, outputs at reset values. Next LW at 0x40 with rdata=0x12345678 → ld_data=0x12345678.
